aes_stream_ctrl: RTL and testbench

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES streaming controller: FSM states, group geometry
// and a word-select helper for 128-bit blocks carried as four 32-bit words.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } aes_ctrl_state_t;

  localparam int AES_WORDS   = 4;
  localparam int AES_ENG_LAT = 12;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w_s;
    case (idx)
      2'd0:    w_s = blk[127:96];
      2'd1:    w_s = blk[95:64];
      2'd2:    w_s = blk[63:32];
      2'd3:    w_s = blk[31:0];
      default: w_s = 32'd0;
    endcase
    return w_s;
  endfunction

endpackage

// File: rtl/aes_stream_ctrl.sv
// Streaming front end for an external AES cipher engine: gathers 4-word key and text
// groups, launches the engine, and drains the 128-bit ciphertext as four words.
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_key,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         eng_ld,
  output logic [127:0] eng_key,
  output logic [127:0] eng_text,
  input  logic         eng_done,
  input  logic [127:0] eng_text_out,
  output logic         err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  aes_ctrl_state_t state_r;
  logic [1:0]   word_cnt_r;
  logic [7:0]   tmo_cnt_r;
  logic [95:0]  grp_r;
  logic         grp_key_r;
  logic         key_valid_r;
  logic [127:0] key_r;
  logic [127:0] text_r;
  logic [127:0] buf_r;
  logic         s_ready_r;
  logic         m_valid_r;
  logic [31:0]  m_data_r;
  logic         eng_ld_r;
  logic         err_r;

  logic         s_fire_s;
  logic         m_fire_s;
  logic [127:0] grp_full_s;

  assign s_fire_s   = s_valid && s_ready_r;
  assign m_fire_s   = m_valid_r && m_ready;
  assign grp_full_s = {grp_r, s_data};

  assign s_ready  = s_ready_r;
  assign m_valid  = m_valid_r;
  assign m_data   = m_data_r;
  assign eng_ld   = eng_ld_r;
  assign eng_key  = key_r;
  assign eng_text = text_r;
  assign err      = err_r;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_COLLECT;
      word_cnt_r  <= 2'd0;
      tmo_cnt_r   <= 8'd0;
      grp_r       <= 96'd0;
      grp_key_r   <= 1'b0;
      key_valid_r <= 1'b0;
      key_r       <= 128'd0;
      text_r      <= 128'd0;
      buf_r       <= 128'd0;
      s_ready_r   <= 1'b1;
      m_valid_r   <= 1'b0;
      m_data_r    <= 32'd0;
      eng_ld_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (s_fire_s) begin
            grp_r      <= {grp_r[63:0], s_data};
            word_cnt_r <= word_cnt_r + 2'd1;
            // Group type is fixed by word 0; later words only flag disagreement.
            if (word_cnt_r == 2'd0) begin
              grp_key_r <= s_key;
            end else if (s_key != grp_key_r) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
            if (word_cnt_r == 2'd3) begin
              if (grp_key_r) begin
                key_r       <= grp_full_s;
                key_valid_r <= 1'b1;
              end else if (key_valid_r) begin
                text_r    <= grp_full_s;
                eng_ld_r  <= 1'b1;
                s_ready_r <= 1'b0;
                state_r   <= ST_LAUNCH;
              end else begin
                err_r <= 1'b1;
              end
            end
          end
        end
        ST_LAUNCH: begin
          eng_ld_r  <= 1'b0;
          tmo_cnt_r <= 8'd0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            buf_r      <= eng_text_out;
            m_data_r   <= word_sel(eng_text_out, 2'd0);
            m_valid_r  <= 1'b1;
            word_cnt_r <= 2'd0;
            state_r    <= ST_DRAIN;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_r     <= 1'b1;
            tmo_cnt_r <= 8'd0;
            s_ready_r <= 1'b1;
            state_r   <= ST_COLLECT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (m_fire_s) begin
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              m_valid_r <= 1'b0;
              m_data_r  <= 32'd0;
              s_ready_r <= 1'b1;
              state_r   <= ST_COLLECT;
            end else begin
              m_data_r <= word_sel(buf_r, word_cnt_r + 2'd1);
            end
          end
        end
        default: begin
          eng_ld_r  <= 1'b0;
          m_valid_r <= 1'b0;
          s_ready_r <= 1'b1;
          state_r   <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl with a behavioural 12-cycle engine stand-in.
module tb_aes_stream_ctrl;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = 32'd0;
  logic         s_key = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         eng_ld;
  logic [127:0] eng_key;
  logic [127:0] eng_text;
  logic         eng_done;
  logic [127:0] eng_text_out = 128'd0;
  logic         err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ld_cnt = 0;
  int mv_cnt = 0;
  int eng_cnt = 0;
  logic eng_dead = 1'b0;

  aes_stream_ctrl #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .eng_ld(eng_ld), .eng_key(eng_key), .eng_text(eng_text),
    .eng_done(eng_done), .eng_text_out(eng_text_out), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_ld) ld_cnt <= ld_cnt + 1;
    if (m_valid) mv_cnt <= mv_cnt + 1;
  end

  // Stand-in cipher: known FIPS-197 answer, otherwise an arbitrary keyed mix.
  function automatic logic [127:0] eng_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_K && t == FIPS_T) return FIPS_C;
    return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_3c3c3c3c_0f0f0f0f_96969696;
  endfunction

  // Engine: samples the load pulse, raises done 12 rising edges later.
  always @(negedge clk) begin
    if (eng_ld) begin
      eng_cnt      <= 13;
      eng_text_out <= eng_fn(eng_key, eng_text);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign eng_done = (eng_cnt == 1) && !eng_dead;

  function automatic logic [31:0] wsel(input logic [127:0] blk, input int i);
    return blk[127 - 32*i -: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Sends one 4-word group; bad_idx selects a word whose s_key is inverted (-1 = none).
  task automatic send_group(input logic kflag, input logic [127:0] blk, input int bad_idx,
                            output int t_acc);
    for (int w = 0; w < 4; w++) begin
      int n = 0;
      s_valid = 1'b1;
      s_data  = wsel(blk, w);
      s_key   = (w == bad_idx) ? ~kflag : kflag;
      while (!s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        chk("s_ready_timeout", 128'(n), 128'd0);
      end
      @(negedge clk);
    end
    t_acc   = cyc;
    s_valid = 1'b0;
  endtask

  // Receives one block with m_ready following the 4-bit cyclic pattern pat.
  task automatic recv_block(input logic [127:0] exp, input logic [3:0] pat,
                            output int t_first, output int t_last);
    int n = 0;
    int idx = 0;
    int k = 0;
    logic rdy;
    t_first = -1;
    t_last  = -1;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("m_valid_timeout", 128'(n), 128'd0);
    end else begin
      t_first = cyc;
      while (idx < 4 && k < 100) begin
        chk("m_valid_drain", 128'(m_valid), 128'd1);
        chk("m_data_word", 128'(m_data), 128'(wsel(exp, idx)));
        rdy = pat[k % 4];
        m_ready = rdy;
        k++;
        @(negedge clk);
        if (rdy) idx++;
      end
      m_ready = 1'b0;
      t_last = cyc;
      chk("m_valid_after_drain", 128'(m_valid), 128'd0);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic [127:0] exp_ct;
    logic         resend_key;
    logic [3:0]   pat;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int t_acc, t_first, t_last, ld0, mv0, n;
    logic [127:0] cur_key, blk, k2;
    logic key_ok, exp_err;

    vecs[0] = '{FIPS_K, FIPS_T, FIPS_C, 1'b1, 4'b1111};
    vecs[1] = '{FIPS_K, 128'h0123456789abcdef_fedcba9876543210,
                eng_fn(FIPS_K, 128'h0123456789abcdef_fedcba9876543210), 1'b0, 4'b1001};
    vecs[2] = '{FIPS_K, 128'hdeadbeef_00000000_ffffffff_12345678,
                eng_fn(FIPS_K, 128'hdeadbeef_00000000_ffffffff_12345678), 1'b0, 4'b1001};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_s_ready", 128'(s_ready), 128'd1);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_data", 128'(m_data), 128'd0);
    chk("rst_eng_ld", 128'(eng_ld), 128'd0);
    chk("rst_eng_key", eng_key, 128'd0);
    chk("rst_eng_text", eng_text, 128'd0);
    chk("rst_err", 128'(err), 128'd0);

    // Text before any key
    ld0 = ld_cnt;
    send_group(1'b0, FIPS_T, -1, t_acc);
    repeat (3) @(negedge clk);
    chk("nokey_err", 128'(err), 128'd1);
    chk("nokey_s_ready", 128'(s_ready), 128'd1);
    chk("nokey_no_ld", 128'(ld_cnt), 128'(ld0));

    // Table vectors: FIPS with latency, then back-to-back blocks with stalls
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].resend_key) begin
        send_group(1'b1, vecs[i].key, -1, t_acc);
        chk("tbl_eng_key", eng_key, vecs[i].key);
      end
      send_group(1'b0, vecs[i].text, -1, t_acc);
      chk("tbl_eng_ld", 128'(eng_ld), 128'd1);
      recv_block(vecs[i].exp_ct, vecs[i].pat, t_first, t_last);
      if (i == 0) begin
        chk("lat_first_valid", 128'(t_first), 128'(t_acc + 13));
        chk("lat_last_accept", 128'(t_last), 128'(t_acc + 17));
      end
      chk("tbl_err", 128'(err), 128'd0);
    end

    // Key group with wrong s_key on word 2 still loads the key
    k2 = 128'h11112222_33334444_55556666_77778888;
    send_group(1'b1, k2, 2, t_acc);
    chk("keymis_err", 128'(err), 128'd1);
    chk("keymis_eng_key", eng_key, k2);
    send_group(1'b0, FIPS_T, -1, t_acc);
    recv_block(eng_fn(k2, FIPS_T), 4'b1111, t_first, t_last);

    // Reset in the middle of a drain
    do_reset();
    send_group(1'b1, FIPS_K, -1, t_acc);
    send_group(1'b0, FIPS_T, -1, t_acc);
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    chk("mid_before_rst_valid", 128'(m_valid), 128'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_m_valid", 128'(m_valid), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    ld0 = ld_cnt;
    send_group(1'b0, FIPS_T, -1, t_acc);
    repeat (2) @(negedge clk);
    chk("mid_rst_keylost_err", 128'(err), 128'd1);
    chk("mid_rst_no_ld", 128'(ld_cnt), 128'(ld0));

    // Engine never answers: timeout after 20 cycles in WAIT
    do_reset();
    eng_dead = 1'b1;
    send_group(1'b1, FIPS_K, -1, t_acc);
    send_group(1'b0, FIPS_T, -1, t_acc);
    mv0 = mv_cnt;
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err", 128'(err), 128'd1);
    chk("tmo_time", 128'(cyc), 128'(t_acc + 21));
    @(negedge clk);
    chk("tmo_s_ready", 128'(s_ready), 128'd1);
    chk("tmo_no_m_valid", 128'(mv_cnt), 128'(mv0));
    eng_dead = 1'b0;

    // Random traffic against a block-level model
    do_reset();
    key_ok  = 1'b0;
    exp_err = 1'b0;
    cur_key = 128'd0;
    for (int it = 0; it < 30; it++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        int bad;
        bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1;
        send_group(1'b1, blk, bad, t_acc);
        cur_key = blk;
        key_ok  = 1'b1;
        if (bad >= 0) exp_err = 1'b1;
        chk("rnd_eng_key", eng_key, cur_key);
      end else begin
        ld0 = ld_cnt;
        send_group(1'b0, blk, -1, t_acc);
        if (key_ok) begin
          recv_block(eng_fn(cur_key, blk), 4'($urandom_range(1, 15)), t_first, t_last);
        end else begin
          exp_err = 1'b1;
          @(negedge clk);
          chk("rnd_no_ld", 128'(ld_cnt), 128'(ld0));
        end
      end
      chk("rnd_err", 128'(err), 128'(exp_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
